// File: rtl/ff_bank_pkg.sv
// Shared types and constants for the two-requester flip-flop bank scheduler.
package ff_bank_pkg;

  typedef enum logic [1:0] {
    OP_WRITE     = 2'b00,
    OP_READ      = 2'b01,
    OP_SET       = 2'b10,
    OP_CLEAR_ALL = 2'b11
  } op_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/ff_bank_scheduler_if.sv
// Command/response bundle for requesters A and B plus the sweep status flag.
interface ff_bank_scheduler_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
);
  logic             a_valid;
  logic             a_ready;
  logic [1:0]       a_op;
  logic [AW-1:0]    a_addr;
  logic [WIDTH-1:0] a_wdata;
  logic             a_rvalid;
  logic [WIDTH-1:0] a_rdata;

  logic             b_valid;
  logic             b_ready;
  logic [1:0]       b_op;
  logic [AW-1:0]    b_addr;
  logic [WIDTH-1:0] b_wdata;
  logic             b_rvalid;
  logic [WIDTH-1:0] b_rdata;

  logic             busy;

  modport master (
    output a_valid, a_op, a_addr, a_wdata,
    output b_valid, b_op, b_addr, b_wdata,
    input  a_ready, a_rvalid, a_rdata,
    input  b_ready, b_rvalid, b_rdata,
    input  busy
  );

  modport slave (
    input  a_valid, a_op, a_addr, a_wdata,
    input  b_valid, b_op, b_addr, b_wdata,
    output a_ready, a_rvalid, a_rdata,
    output b_ready, b_rvalid, b_rdata,
    output busy
  );
endinterface

// File: rtl/ff_bank_scheduler_word.sv
// One storage word: async reset to 0, synchronous clear, set-all-ones and load.
module ff_word_set_reset #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             set,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      q <= '0;
    else if (clear) q <= '0;
    else if (set)   q <= '1;
    else if (load)  q <= d;
  end

endmodule

// File: rtl/ff_bank_scheduler.sv
// Round-robin scheduler granting two requesters access to a bank of set/reset words,
// including a DEPTH-cycle CLEAR_ALL sweep that blocks both requesters.
module ff_bank_scheduler
  import ff_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input logic                clk,
  input logic                reset,
  ff_bank_scheduler_if.slave bus
);

  state_t           state;
  logic [AW-1:0]    sweep_ptr;
  logic             rr_last;
  logic             grant_a, grant_b, accept;
  op_t              op_sel;
  logic [AW-1:0]    addr_sel;
  logic [WIDTH-1:0] wdata_sel;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] q [DEPTH];
  logic             a_rvalid_p1, b_rvalid_p1;
  logic [WIDTH-1:0] a_rdata_p1, b_rdata_p1;

  // Ready is gated by reset so nothing is advertised while the bank is held cleared.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state == ST_IDLE && !reset) begin
      if (bus.a_valid && (!bus.b_valid || rr_last == REQ_B)) grant_a = 1'b1;
      else if (bus.b_valid)                                  grant_b = 1'b1;
    end
  end

  assign accept    = grant_a | grant_b;
  assign op_sel    = grant_b ? op_t'(bus.b_op) : op_t'(bus.a_op);
  assign addr_sel  = grant_b ? bus.b_addr : bus.a_addr;
  assign wdata_sel = grant_b ? bus.b_wdata : bus.a_wdata;

  // An address with no matching word reads back as zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr_sel == AW'(i)) rd_word = q[i];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    ff_word_set_reset #(.WIDTH(WIDTH)) u_word (
      .clk   (clk),
      .reset (reset),
      .load  (accept && op_sel == OP_WRITE && addr_sel == AW'(i)),
      .set   (accept && op_sel == OP_SET   && addr_sel == AW'(i)),
      .clear (state == ST_SWEEP && sweep_ptr == AW'(i)),
      .d     (wdata_sel),
      .q     (q[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      sweep_ptr <= '0;
      rr_last   <= REQ_B;
    end else begin
      if (accept) rr_last <= grant_b ? REQ_B : REQ_A;
      case (state)
        ST_IDLE: begin
          if (accept && op_sel == OP_CLEAR_ALL) begin
            state     <= ST_SWEEP;
            sweep_ptr <= '0;
          end
        end
        ST_SWEEP: begin
          if (sweep_ptr == AW'(DEPTH - 1)) begin
            state     <= ST_IDLE;
            sweep_ptr <= '0;
          end else begin
            sweep_ptr <= sweep_ptr + AW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read response stage: one cycle after accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rvalid_p1 <= 1'b0;
      b_rvalid_p1 <= 1'b0;
      a_rdata_p1  <= '0;
      b_rdata_p1  <= '0;
    end else begin
      a_rvalid_p1 <= grant_a && op_sel == OP_READ;
      b_rvalid_p1 <= grant_b && op_sel == OP_READ;
      if (grant_a && op_sel == OP_READ) a_rdata_p1 <= rd_word;
      if (grant_b && op_sel == OP_READ) b_rdata_p1 <= rd_word;
    end
  end

  assign bus.a_ready  = grant_a;
  assign bus.b_ready  = grant_b;
  assign bus.a_rvalid = a_rvalid_p1;
  assign bus.b_rvalid = b_rvalid_p1;
  assign bus.a_rdata  = a_rdata_p1;
  assign bus.b_rdata  = b_rdata_p1;
  assign bus.busy     = (state == ST_SWEEP);

endmodule

// File: tb/tb_ff_bank_scheduler.sv
// Directed bench for ff_bank_scheduler: a vector table plus hand-written sweep/reset sequences.
module tb_ff_bank_scheduler;

  localparam logic [1:0] W = 2'b00, R = 2'b01, S = 2'b10, C = 2'b11;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   passed = 0;

  ff_bank_scheduler_if #(.WIDTH(8), .AW(2)) bus ();

  ff_bank_scheduler #(.WIDTH(8), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       av;
    logic [1:0] aop;
    logic [1:0] aaddr;
    logic [7:0] awd;
    logic       bv;
    logic [1:0] bop;
    logic [1:0] baddr;
    logic [7:0] bwd;
    logic       ear;
    logic       ebr;
    logic       earv;
    logic [7:0] eard;
    logic       ebrv;
    logic [7:0] ebrd;
    logic       ebusy;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic av, input logic [1:0] aop, input logic [1:0] aaddr,
                       input logic [7:0] awd, input logic bv, input logic [1:0] bop,
                       input logic [1:0] baddr, input logic [7:0] bwd);
    bus.a_valid = av;  bus.a_op = aop;  bus.a_addr = aaddr;  bus.a_wdata = awd;
    bus.b_valid = bv;  bus.b_op = bop;  bus.b_addr = baddr;  bus.b_wdata = bwd;
  endtask

  task automatic idle();
    drive(1'b0, W, 2'd0, 8'h00, 1'b0, W, 2'd0, 8'h00);
  endtask

  task automatic write_a(input logic [1:0] addr, input logic [7:0] data);
    @(negedge clk);
    drive(1'b1, W, addr, data, 1'b0, W, 2'd0, 8'h00);
    #1 chk("write_a ready", bus.a_ready, 1'b1);
  endtask

  task automatic read_a(input logic [1:0] addr, input logic [7:0] exp);
    @(negedge clk);
    drive(1'b1, R, addr, 8'h00, 1'b0, W, 2'd0, 8'h00);
    #1 chk("read_a ready", bus.a_ready, 1'b1);
    @(negedge clk);
    idle();
    #1;
    chk("read_a rvalid", bus.a_rvalid, 1'b1);
    chk("read_a rdata", bus.a_rdata, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          av aop aa awd    bv bop ba bwd    ar br arv ard    brv brd    busy
    vecs[0]  = '{0, W, 0, 8'h00, 0, W, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 0};
    vecs[1]  = '{1, W, 1, 8'h5A, 0, W, 0, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 0};
    vecs[2]  = '{1, R, 1, 8'h00, 0, W, 0, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 0};
    vecs[3]  = '{0, W, 0, 8'h00, 0, W, 0, 8'h00, 0, 0, 1, 8'h5A, 0, 8'h00, 0};
    vecs[4]  = '{0, W, 0, 8'h00, 1, R, 0, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00, 0};
    vecs[5]  = '{0, W, 0, 8'h00, 0, W, 0, 8'h00, 0, 0, 0, 8'h00, 1, 8'h00, 0};
    vecs[6]  = '{1, W, 2, 8'h01, 1, W, 3, 8'h02, 1, 0, 0, 8'h00, 0, 8'h00, 0};
    vecs[7]  = '{1, R, 2, 8'h00, 1, W, 3, 8'h02, 0, 1, 0, 8'h00, 0, 8'h00, 0};
    vecs[8]  = '{1, R, 2, 8'h00, 1, R, 3, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 0};
    vecs[9]  = '{0, W, 0, 8'h00, 1, R, 3, 8'h00, 0, 1, 1, 8'h01, 0, 8'h00, 0};
    vecs[10] = '{0, W, 0, 8'h00, 0, W, 0, 8'h00, 0, 0, 0, 8'h00, 1, 8'h02, 0};
    vecs[11] = '{0, W, 0, 8'h00, 1, S, 2, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00, 0};
    vecs[12] = '{0, W, 0, 8'h00, 1, R, 2, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00, 0};
    vecs[13] = '{1, R, 1, 8'h00, 0, W, 0, 8'h00, 1, 0, 0, 8'h00, 1, 8'hFF, 0};
    vecs[14] = '{1, R, 3, 8'h00, 0, W, 0, 8'h00, 1, 0, 1, 8'h5A, 0, 8'h00, 0};
    vecs[15] = '{0, W, 0, 8'h00, 0, W, 0, 8'h00, 0, 0, 1, 8'h02, 0, 8'h00, 0};
    vecs[16] = '{1, W, 0, 8'hC3, 0, W, 0, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 0};
    vecs[17] = '{1, R, 0, 8'h00, 0, W, 0, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 0};
    vecs[18] = '{0, W, 0, 8'h00, 0, W, 0, 8'h00, 0, 0, 1, 8'hC3, 0, 8'h00, 0};

    idle();
    #12;
    chk("reset a_ready", bus.a_ready, 1'b0);
    chk("reset b_ready", bus.b_ready, 1'b0);
    chk("reset busy", bus.busy, 1'b0);
    chk("reset a_rvalid", bus.a_rvalid, 1'b0);
    chk("reset a_rdata", bus.a_rdata, 8'h00);
    chk("reset b_rdata", bus.b_rdata, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vecs[i].av, vecs[i].aop, vecs[i].aaddr, vecs[i].awd,
            vecs[i].bv, vecs[i].bop, vecs[i].baddr, vecs[i].bwd);
      #1;
      chk($sformatf("vec%0d a_ready", i), bus.a_ready, vecs[i].ear);
      chk($sformatf("vec%0d b_ready", i), bus.b_ready, vecs[i].ebr);
      chk($sformatf("vec%0d a_rvalid", i), bus.a_rvalid, vecs[i].earv);
      chk($sformatf("vec%0d b_rvalid", i), bus.b_rvalid, vecs[i].ebrv);
      chk($sformatf("vec%0d busy", i), bus.busy, vecs[i].ebusy);
      if (vecs[i].earv) chk($sformatf("vec%0d a_rdata", i), bus.a_rdata, vecs[i].eard);
      if (vecs[i].ebrv) chk($sformatf("vec%0d b_rdata", i), bus.b_rdata, vecs[i].ebrd);
    end

    // CLEAR_ALL sweep with B holding a READ of the last word.
    for (int i = 0; i < 4; i++) write_a(2'(i), 8'(8'h11 * (i + 1)));
    read_a(2'd3, 8'h44);
    @(negedge clk);
    drive(1'b1, C, 2'd0, 8'h00, 1'b0, W, 2'd0, 8'h00);
    #1 chk("clear accept a_ready", bus.a_ready, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b0, W, 2'd0, 8'h00, 1'b1, R, 2'd3, 8'h00);
      #1;
      chk($sformatf("sweep%0d busy", k), bus.busy, 1'b1);
      chk($sformatf("sweep%0d b_ready", k), bus.b_ready, 1'b0);
    end
    @(negedge clk);
    #1;
    chk("post sweep busy", bus.busy, 1'b0);
    chk("post sweep b_ready", bus.b_ready, 1'b1);
    @(negedge clk);
    idle();
    #1;
    chk("post sweep b_rvalid", bus.b_rvalid, 1'b1);
    chk("post sweep b_rdata", bus.b_rdata, 8'h00);
    for (int i = 0; i < 3; i++) read_a(2'(i), 8'h00);

    // Reset asserted during the second sweep cycle.
    for (int i = 0; i < 4; i++) write_a(2'(i), 8'(8'h11 * (i + 1)));
    read_a(2'd2, 8'h33);
    @(negedge clk);
    drive(1'b1, C, 2'd0, 8'h00, 1'b0, W, 2'd0, 8'h00);
    #1 chk("clear2 accept a_ready", bus.a_ready, 1'b1);
    @(negedge clk);
    drive(1'b1, R, 2'd3, 8'h00, 1'b1, R, 2'd1, 8'h00);
    #1 chk("clear2 busy", bus.busy, 1'b1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midsweep reset busy", bus.busy, 1'b0);
    chk("midsweep reset a_ready", bus.a_ready, 1'b0);
    chk("midsweep reset b_ready", bus.b_ready, 1'b0);
    chk("midsweep reset a_rvalid", bus.a_rvalid, 1'b0);
    chk("midsweep reset b_rvalid", bus.b_rvalid, 1'b0);
    chk("midsweep reset a_rdata", bus.a_rdata, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("after reset tie a_ready", bus.a_ready, 1'b1);
    chk("after reset tie b_ready", bus.b_ready, 1'b0);
    @(negedge clk);
    drive(1'b0, W, 2'd0, 8'h00, 1'b1, R, 2'd1, 8'h00);
    #1;
    chk("after reset a_rvalid", bus.a_rvalid, 1'b1);
    chk("after reset a_rdata w3", bus.a_rdata, 8'h00);
    chk("after reset b_ready", bus.b_ready, 1'b1);
    @(negedge clk);
    idle();
    #1;
    chk("after reset b_rvalid", bus.b_rvalid, 1'b1);
    chk("after reset b_rdata w1", bus.b_rdata, 8'h00);
    read_a(2'd2, 8'h00);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
